// File: rtl/shift_add_mult4.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult4 (with local ripple adder fulladdR)
//  Function : Sequential 4x4 unsigned shift-and-add multiplier with an 8-bit
//             registered product. The multiplier performs one add per cycle
//             through a single 4-bit ripple-carry adder.
//  Option   : `define MULT_ZERO_SKIP_EN to enable early termination once
//             the remaining multiplier bits are all zero.
//  Revision : 1.0 - initial release
// ============================================================================

// 4-bit ripple-carry adder
module fulladdR (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] s_o,
   output logic       cout_o
);
   logic [4:0] w_carry;

   assign w_carry[0] = cin_i;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bit
         assign s_o[gi]       = a_i[gi] ^ b_i[gi] ^ w_carry[gi];
         assign w_carry[gi+1] = (a_i[gi] & b_i[gi]) | (w_carry[gi] & (a_i[gi] ^ b_i[gi]));
      end
   endgenerate

   assign cout_o = w_carry[4];
endmodule

module shift_add_mult4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] product
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] m_q, m_d;
   logic [3:0] acc_q, acc_d;
   logic [3:0] q_q, q_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] product_q, product_d;

   logic [3:0] w_sum;
   logic       w_cout;
   logic       w_sel_c;
   logic [3:0] w_sel_s;
   logic [3:0] w_acc_step;
   logic [3:0] w_q_step;

   // single arithmetic element: acc + m
   fulladdR u_add (
      .a_i    (acc_q),
      .b_i    (m_q),
      .cin_i  (1'b0),
      .s_o    (w_sum),
      .cout_o (w_cout)
   );

   // pick the sum when the current multiplier bit is set, then shift {acc,q} right
   always_comb begin
      w_sel_c    = q_q[0] ? w_cout : 1'b0;
      w_sel_s    = q_q[0] ? w_sum  : acc_q;
      w_acc_step = {w_sel_c, w_sel_s[3:1]};
      w_q_step   = {w_sel_s[0], q_q[3:1]};
   end

`ifdef MULT_ZERO_SKIP_EN
   logic       w_rest_zero;
   logic [2:0] w_shamt;
   logic [7:0] w_early_prod;

   // remaining unprocessed multiplier bits q[3-cnt:0] all zero -> finish now
   always_comb begin
      w_rest_zero = 1'b0;
      case (cnt_q)
         2'd0:    w_rest_zero = (q_q[3:0] == 4'd0);
         2'd1:    w_rest_zero = (q_q[2:0] == 3'd0);
         2'd2:    w_rest_zero = (q_q[1:0] == 2'd0);
         default: w_rest_zero = (q_q[0] == 1'b0);
      endcase
      w_shamt      = 3'd4 - {1'b0, cnt_q};
      w_early_prod = {acc_q, q_q} >> w_shamt;
   end
`endif

   // next-state and datapath control
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = 4'd0;
               cnt_d   = 2'd0;
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef MULT_ZERO_SKIP_EN
            if (w_rest_zero) begin
               product_d = w_early_prod;
               state_d   = DONE;
            end else begin
`else
            begin
`endif
               acc_d = w_acc_step;
               q_d   = w_q_step;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  product_d = {w_acc_step, w_q_step};
                  state_d   = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= 4'd0;
         acc_q     <= 4'd0;
         q_q       <= 4'd0;
         cnt_q     <= 2'd0;
         product_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = product_q;
endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult4
//  Function : Self-checking bench for shift_add_mult4 (directed vector table
//             plus hand-written multi-cycle sequences). Honours
//             MULT_ZERO_SKIP_EN for expected latencies.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult4;
   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec_t;

   vec_t vecs[12];

   shift_add_mult4 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // cycles from acceptance to done
   function automatic int exp_lat(input logic [3:0] bb);
`ifdef MULT_ZERO_SKIP_EN
      if (bb == 4'd0) return 1;
      if (bb[3]) return 4;
      if (bb[2]) return 4;
      if (bb[1]) return 3;
      return 2;
`else
      return 4;
`endif
   endfunction

   // accept one operation and wait for its done pulse
   task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] exp,
                         input bit chk_lat);
      int lat;
      a = ta;
      b = tb;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
      if (chk_lat) chk("busy_after_accept", {31'd0, busy}, 32'd1);
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done expected done a=%0d b=%0d", ta, tb);
      end else begin
         chk("product", {24'd0, product}, {24'd0, exp});
         if (chk_lat) chk("latency", lat, exp_lat(tb));
         if (chk_lat) chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      int ndone;
      int nstart;
      int last;
      logic [7:0] p0;

      n_cmp = 0;
      n_bad = 0;
      vecs[0]  = '{4'd15, 4'd15, 8'hE1};
      vecs[1]  = '{4'd9,  4'd6,  8'h36};
      vecs[2]  = '{4'd2,  4'd3,  8'h06};
      vecs[3]  = '{4'd0,  4'd0,  8'h00};
      vecs[4]  = '{4'd15, 4'd1,  8'h0F};
      vecs[5]  = '{4'd1,  4'd15, 8'h0F};
      vecs[6]  = '{4'd5,  4'd1,  8'h05};
      vecs[7]  = '{4'd12, 4'd0,  8'h00};
      vecs[8]  = '{4'd3,  4'd8,  8'h18};
      vecs[9]  = '{4'd10, 4'd10, 8'h64};
      vecs[10] = '{4'd7,  4'd7,  8'h31};
      vecs[11] = '{4'd8,  4'd13, 8'h68};

      // reset, then idle hold
      rst = 1'b1;
      start = 1'b0;
      a = 4'd0;
      b = 4'd0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_product", {24'd0, product}, 32'h0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      a = 4'd9;
      b = 4'd9;
      for (int i = 0; i < 4; i++) tick();
      chk("idle_product", {24'd0, product}, 32'h0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);

      // directed vector table
      for (int i = 0; i < 12; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);

      // 15*15 held for ten cycles
      run_op(4'd15, 4'd15, 8'hE1, 1'b1);
      tick();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      for (int i = 0; i < 9; i++) tick();
      chk("product_held", {24'd0, product}, 32'hE1);

      // back-to-back: start held high, done every 5 cycles
      a = 4'd9;
      b = 4'd6;
      start = 1'b1;
      tick();
      last = 0;
      ndone = 0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (done) begin
            ndone++;
            chk("b2b_interval", i - last, (ndone == 1) ? 4 : 5);
            chk("b2b_product", {24'd0, product}, 32'h36);
            last = i;
         end
      end
      chk("b2b_count", ndone, 3);
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("b2b_drain_idle", {30'd0, busy, done}, 32'd0);

      // reset abort during RUN
      a = 4'd7;
      b = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_product", {24'd0, product}, 32'h0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      chk("abort_idle_busy", {31'd0, busy}, 32'd0);
      run_op(4'd2, 4'd3, 8'h06, 1'b1);

      // exhaustive pairs
      nstart = 0;
      ndone = 0;
      for (int i = 0; i < 256; i++) begin
         logic [3:0] xa;
         logic [3:0] xb;
         xa = 4'(i >> 4);
         xb = 4'(i);
         p0 = 8'(xa * xb);
         nstart++;
         run_op(xa, xb, p0, 1'b0);
         if (done) ndone++;
      end
      chk("exh_done_count", ndone, nstart);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
